braille_quiz_sequencer: RTL and testbench
=========================================

// Module: braille_quiz_sequencer
// PURPOSE
//  Lesson controller for the trainer. Steps through the braille character ROM.
//  For each character it shows the 6-dot pattern for a fixed number of seconds,
//  then blanks it and waits, with a time limit, for the user to key in the pattern.
//  It scores each answer and holds feedback for one second. All time is counted in
//  1 s ticks from the shared one-second timeout generator.
// PARAMETERS
//  NUM_CHARS    26  characters per lesson; ROM addresses 0..NUM_CHARS-1
//  ADDR_W       5   ROM address width; 2**ADDR_W >= NUM_CHARS
//  SHOW_SECS    3   seconds the pattern is displayed; 1..15
//  ANSWER_SECS  5   seconds allowed to answer; 1..15
//  SCORE_W      5   score width; 2**SCORE_W > NUM_CHARS
// PORTS
//  clk            in   1        system clock
//  rst            in   1        reset, synchronous, active-low
//  timeout1s      in   1        1-cycle pulse, once per second
//  start          in   1        level/pulse; begins a lesson from IDLE or DONE
//  answer_valid   in   1        1-cycle pulse; answer_pattern is valid this cycle
//  answer_pattern in   6        user-entered dots, bit0=dot1 .. bit5=dot6
//  rom_data       in   6        ROM pattern; valid 1 cycle after rom_addr is presented
//  rom_addr       out  ADDR_W   current character index
//  display_en     out  1        1 while the pattern is shown
//  display_pattern out 6        pattern driven to the dot LEDs; 0 when display_en=0
//  correct        out  1        high for the whole FEEDBACK state if the answer matched
//  wrong          out  1        high for the whole FEEDBACK state if mismatched or timed out
//  score          out  SCORE_W  count of correct answers in the current lesson
//  busy           out  1        1 in every state except IDLE and DONE
//  done           out  1        1 in DONE
// BEHAVIOUR
//  - Reset (rst==0 at posedge): state=IDLE. rom_addr, display_en, display_pattern,
//    correct, wrong, score, busy and done are all 0. Internal sec_cnt is 0.
//    Reset takes priority over every other input, including mid-lesson.
//  - All outputs are registered. States: IDLE, FETCH, SHOW, ANSWER, FEEDBACK, DONE.
//  - IDLE/DONE: on start=1, go to FETCH with rom_addr=0 and score=0.
//    In DONE, score is held until start. start is ignored in all other states.
//  - FETCH: lasts exactly 2 cycles (address, then ROM latency). In the 2nd cycle,
//    latch rom_data into target, clear sec_cnt, and go to SHOW.
//  - SHOW: display_en=1, display_pattern=target. sec_cnt increments on each
//    timeout1s. On the tick that makes sec_cnt==SHOW_SECS, clear sec_cnt and go to
//    ANSWER. A pending tick already high on entry to SHOW counts.
//  - ANSWER: display off. On answer_valid: correct=1 if answer_pattern==target,
//    else wrong=1; go to FEEDBACK. On the tick that makes sec_cnt==ANSWER_SECS with
//    no answer: wrong=1; go to FEEDBACK. If answer_valid and the final tick occur in
//    the same cycle, the answer wins. answer_valid outside ANSWER is ignored.
//  - FEEDBACK: on entry, score increments by 1 if correct. Stay until the next
//    timeout1s, then clear correct and wrong. If rom_addr==NUM_CHARS-1, go to DONE;
//    else rom_addr+1 and go to FETCH.
//  - score never wraps: max NUM_CHARS < 2**SCORE_W by parameter rule.
//  - correct and wrong are never both 1.
//  - Latency from start to display_en=1 is 3 cycles.
// TESTING
//  1 rst=0 mid-SHOW at char 4 -> next cycle IDLE, all outputs 0, rom_addr=0.
//  2 start, rom_data=6'h01 at addr 0; after 3 ticks answer 6'h01
//    -> display_en for 3 s, correct=1 for 1 s, score=1, rom_addr=1.
//  3 No answer for 5 ticks in ANSWER -> wrong=1, score unchanged, advance.
//  4 answer_valid with wrong pattern 6'h03 on the same cycle as the 5th tick
//    -> wrong=1 via answer path, exactly one FEEDBACK.
//  5 NUM_CHARS=3, all answers correct -> done=1, busy=0, score=3, rom_addr=2;
//    start restarts at addr 0 with score=0.
//  6 start pulsed during SHOW/ANSWER and answer_valid during SHOW
//    -> no state, score or addr change.

Source files
------------

// File: rtl/braille_quiz_sequencer_if.sv
// Signal bundle between the lesson controller and the trainer front panel / character ROM.
// answer_valid is a one-cycle pulse with no ready: the controller samples it only in ANSWER and drops it elsewhere.
interface braille_quiz_sequencer_if #(
  parameter int ADDR_W  = 5,
  parameter int SCORE_W = 5
);
  logic               timeout1s;
  logic               start;
  logic               answer_valid;
  logic [5:0]         answer_pattern;
  logic [5:0]         rom_data;
  logic [ADDR_W-1:0]  rom_addr;
  logic               display_en;
  logic [5:0]         display_pattern;
  logic               correct;
  logic               wrong;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;
  logic [2:0]         fsm_state;

  modport master (
    output timeout1s, start, answer_valid, answer_pattern, rom_data,
    input  rom_addr, display_en, display_pattern, correct, wrong, score, busy, done, fsm_state
  );

  modport slave (
    input  timeout1s, start, answer_valid, answer_pattern, rom_data,
    output rom_addr, display_en, display_pattern, correct, wrong, score, busy, done, fsm_state
  );
endinterface

// File: rtl/braille_quiz_sequencer.sv
// Braille lesson controller: fetch a character, show it, time the answer, score it,
// hold feedback for one second tick, then move to the next ROM entry.
module braille_quiz_sequencer #(
  parameter int NUM_CHARS   = 26,
  parameter int ADDR_W      = 5,
  parameter int SHOW_SECS   = 3,
  parameter int ANSWER_SECS = 5,
  parameter int SCORE_W     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  braille_quiz_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHOW     = 3'd2,
    S_ANSWER   = 3'd3,
    S_FEEDBACK = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [3:0]         SHOW_LAST   = 4'(SHOW_SECS - 1);
  localparam logic [3:0]         ANSWER_LAST = 4'(ANSWER_SECS - 1);
  localparam logic [3:0]         SEC_ONE     = 4'd1;
  localparam logic [ADDR_W-1:0]  LAST_ADDR   = ADDR_W'(NUM_CHARS - 1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE    = ADDR_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  state_t             state;
  logic               fetch_ph;
  logic [3:0]         sec_cnt;
  logic [5:0]         target;
  logic [ADDR_W-1:0]  rom_addr;
  logic               display_en;
  logic [5:0]         display_pattern;
  logic               correct;
  logic               wrong;
  logic [SCORE_W-1:0] score;
  logic               busy;
  logic               done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= S_IDLE;
      fetch_ph        <= 1'b0;
      sec_cnt         <= 4'd0;
      target          <= 6'd0;
      rom_addr        <= '0;
      display_en      <= 1'b0;
      display_pattern <= 6'd0;
      correct         <= 1'b0;
      wrong           <= 1'b0;
      score           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state    <= S_FETCH;
            fetch_ph <= 1'b0;
            rom_addr <= '0;
            score    <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end

        // First cycle presents the address, second captures the ROM word.
        S_FETCH: begin
          if (!fetch_ph) begin
            fetch_ph <= 1'b1;
          end else begin
            fetch_ph        <= 1'b0;
            target          <= bus.rom_data;
            sec_cnt         <= 4'd0;
            display_en      <= 1'b1;
            display_pattern <= bus.rom_data;
            state           <= S_SHOW;
          end
        end

        S_SHOW: begin
          if (bus.timeout1s) begin
            if (sec_cnt == SHOW_LAST) begin
              sec_cnt         <= 4'd0;
              display_en      <= 1'b0;
              display_pattern <= 6'd0;
              state           <= S_ANSWER;
            end else begin
              sec_cnt <= sec_cnt + SEC_ONE;
            end
          end
        end

        // An answer arriving together with the final tick is scored as an answer.
        S_ANSWER: begin
          if (bus.answer_valid) begin
            sec_cnt <= 4'd0;
            state   <= S_FEEDBACK;
            if (bus.answer_pattern == target) begin
              correct <= 1'b1;
              score   <= score + SCORE_ONE;
            end else begin
              wrong <= 1'b1;
            end
          end else if (bus.timeout1s) begin
            if (sec_cnt == ANSWER_LAST) begin
              sec_cnt <= 4'd0;
              wrong   <= 1'b1;
              state   <= S_FEEDBACK;
            end else begin
              sec_cnt <= sec_cnt + SEC_ONE;
            end
          end
        end

        S_FEEDBACK: begin
          if (bus.timeout1s) begin
            correct <= 1'b0;
            wrong   <= 1'b0;
            if (rom_addr == LAST_ADDR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rom_addr <= rom_addr + ADDR_ONE;
              state    <= S_FETCH;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.rom_addr        = rom_addr;
  assign bus.display_en      = display_en;
  assign bus.display_pattern = display_pattern;
  assign bus.correct         = correct;
  assign bus.wrong           = wrong;
  assign bus.score           = score;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.fsm_state       = state;

endmodule

// File: tb/tb_braille_quiz_sequencer.sv
// Bench for the braille lesson controller: a 26-character and a 3-character instance
// run in lockstep from shared stimulus; feedback events are checked against an expected queue.
module tb_braille_quiz_sequencer;

  localparam int ADDR_W      = 5;
  localparam int SCORE_W     = 5;
  localparam int SHOW_SECS   = 3;
  localparam int ANSWER_SECS = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       timeout1s      = 1'b0;
  logic       start          = 1'b0;
  logic       answer_valid   = 1'b0;
  logic [5:0] answer_pattern = 6'd0;
  logic [5:0] rom_a          = 6'd0;
  logic [5:0] rom_b          = 6'd0;

  braille_quiz_sequencer_if #(.ADDR_W(ADDR_W), .SCORE_W(SCORE_W)) bus_a ();
  braille_quiz_sequencer_if #(.ADDR_W(ADDR_W), .SCORE_W(SCORE_W)) bus_b ();

  braille_quiz_sequencer #(
    .NUM_CHARS(26), .ADDR_W(ADDR_W), .SHOW_SECS(SHOW_SECS),
    .ANSWER_SECS(ANSWER_SECS), .SCORE_W(SCORE_W)
  ) dut (.clk(clk), .rst(rst), .bus(bus_a.slave));

  braille_quiz_sequencer #(
    .NUM_CHARS(3), .ADDR_W(ADDR_W), .SHOW_SECS(SHOW_SECS),
    .ANSWER_SECS(ANSWER_SECS), .SCORE_W(SCORE_W)
  ) dut_small (.clk(clk), .rst(rst), .bus(bus_b.slave));

  assign bus_a.timeout1s      = timeout1s;
  assign bus_a.start          = start;
  assign bus_a.answer_valid   = answer_valid;
  assign bus_a.answer_pattern = answer_pattern;
  assign bus_a.rom_data       = rom_a;
  assign bus_b.timeout1s      = timeout1s;
  assign bus_b.start          = start;
  assign bus_b.answer_valid   = answer_valid;
  assign bus_b.answer_pattern = answer_pattern;
  assign bus_b.rom_data       = rom_b;

  function automatic logic [5:0] rom_val(input int i);
    return 6'((i * 7 + 1) & 63);
  endfunction

  // Character ROM with one cycle of read latency.
  always @(posedge clk) begin
    rom_a <= rom_val(int'(bus_a.rom_addr));
    rom_b <= rom_val(int'(bus_b.rom_addr));
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return 32'({bus_a.rom_addr, bus_a.display_en, bus_a.display_pattern, bus_a.correct,
                bus_a.wrong, bus_a.score, bus_a.busy, bus_a.done});
  endfunction

  function automatic logic [31:0] pack_b();
    return 32'({bus_b.rom_addr, bus_b.display_en, bus_b.display_pattern, bus_b.correct,
                bus_b.wrong, bus_b.score, bus_b.busy, bus_b.done});
  endfunction

  // Scoreboard entry: {correct, wrong, score[4:0], rom_addr[4:0]}
  logic [11:0] exp_q[$];
  logic        fb_prev = 1'b0;
  int          fb_cnt  = 0;

  always @(negedge clk) begin
    logic [11:0] e;
    if (rst && (bus_a.correct || bus_a.wrong) && !fb_prev) begin
      fb_cnt++;
      check("fb_exclusive", 32'(bus_a.correct & bus_a.wrong), 32'd0);
      if (exp_q.size() == 0) begin
        check("fb_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("fb_correct", 32'(bus_a.correct), 32'(e[11]));
        check("fb_wrong", 32'(bus_a.wrong), 32'(e[10]));
        check("fb_score", 32'(bus_a.score), 32'(e[9:5]));
        check("fb_addr", 32'(bus_a.rom_addr), 32'(e[4:0]));
      end
    end
    fb_prev = rst && (bus_a.correct || bus_a.wrong);
  end

  // ---------------- driver tasks ----------------
  typedef enum int {K_OK, K_BAD, K_TO} kind_t;
  typedef struct {
    kind_t      kind;
    logic [5:0] pattern;
    int         ticks_before;
    bit         same_final;
    bit         disturb;
    bit         exp_correct;
  } vec_t;

  vec_t vecs[7];
  int   m_addr  = 0;
  int   m_score = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_tick();
    timeout1s = 1'b1;
    cyc(1);
    timeout1s = 1'b0;
  endtask

  task automatic wait_display();
    for (int i = 0; i < 8 && !bus_a.display_en; i++) cyc(1);
    check("show_reached", 32'(bus_a.display_en), 32'd1);
  endtask

  task automatic run_char(input vec_t v);
    int fb0;
    wait_display();
    check("show_pattern", 32'(bus_a.display_pattern), 32'(rom_val(m_addr)));
    if (v.disturb) begin
      start          = 1'b1;
      answer_valid   = 1'b1;
      answer_pattern = rom_val(m_addr);
      cyc(1);
      start        = 1'b0;
      answer_valid = 1'b0;
      cyc(1);
      check("show_ignores", {bus_a.display_en, bus_a.correct, bus_a.wrong, bus_a.rom_addr, bus_a.score},
            {1'b1, 2'b00, 5'(m_addr), 5'(m_score)});
    end
    for (int i = 0; i < SHOW_SECS; i++) begin
      do_tick();
      if (i == SHOW_SECS - 2) check("show_held", 32'(bus_a.display_en), 32'd1);
      if (i == SHOW_SECS - 1) check("show_ended", 32'({bus_a.display_en, bus_a.display_pattern}), 32'd0);
      cyc(1);
    end
    if (v.disturb) begin
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("answer_ignores_start", {bus_a.display_en, bus_a.busy, bus_a.correct, bus_a.wrong, bus_a.rom_addr, bus_a.score},
            {1'b0, 1'b1, 2'b00, 5'(m_addr), 5'(m_score)});
    end
    for (int i = 0; i < v.ticks_before; i++) begin
      do_tick();
      cyc(1);
    end
    if (v.exp_correct) m_score++;
    exp_q.push_back({v.exp_correct, ~v.exp_correct, 5'(m_score), 5'(m_addr)});
    fb0 = fb_cnt;
    if (v.kind == K_TO) begin
      do_tick();
    end else begin
      answer_valid   = 1'b1;
      answer_pattern = (v.kind == K_OK) ? rom_val(m_addr) : v.pattern;
      timeout1s      = v.same_final;
      cyc(1);
      answer_valid = 1'b0;
      timeout1s    = 1'b0;
    end
    cyc(2);
    check("fb_hold", 32'({bus_a.correct, bus_a.wrong}), 32'({v.exp_correct, ~v.exp_correct}));
    check("fb_once", 32'(fb_cnt - fb0), 32'd1);
    do_tick();
    check("fb_clear", 32'({bus_a.correct, bus_a.wrong}), 32'd0);
    check("next_addr", 32'(bus_a.rom_addr), 32'(m_addr + 1));
    m_addr++;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Table: correct, timeout, wrong-on-final-tick, correct with stray start/answer, then 3 correct.
    vecs[0] = '{kind: K_OK,  pattern: 6'h00, ticks_before: 0, same_final: 1'b0, disturb: 1'b0, exp_correct: 1'b1};
    vecs[1] = '{kind: K_TO,  pattern: 6'h00, ticks_before: ANSWER_SECS - 1, same_final: 1'b0, disturb: 1'b0, exp_correct: 1'b0};
    vecs[2] = '{kind: K_BAD, pattern: 6'h03, ticks_before: ANSWER_SECS - 1, same_final: 1'b1, disturb: 1'b0, exp_correct: 1'b0};
    vecs[3] = '{kind: K_OK,  pattern: 6'h00, ticks_before: 2, same_final: 1'b0, disturb: 1'b1, exp_correct: 1'b1};
    for (int k = 4; k < 7; k++)
      vecs[k] = '{kind: K_OK, pattern: 6'h00, ticks_before: $urandom_range(0, ANSWER_SECS - 1),
                  same_final: 1'b0, disturb: 1'b0, exp_correct: 1'b1};

    cyc(3);
    check("reset_a", pack_a(), 32'd0);
    check("reset_b", pack_b(), 32'd0);
    check("reset_state", 32'(bus_a.fsm_state), 32'd0);
    rst = 1'b1;
    cyc(2);
    check("idle_no_start", pack_a(), 32'd0);

    // Start-to-display latency
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("start_busy", 32'({bus_a.busy, bus_a.display_en}), 32'b10);
    cyc(1);
    check("fetch_dark", 32'(bus_a.display_en), 32'd0);
    cyc(1);
    check("latency3", 32'({bus_a.display_en, bus_a.display_pattern}), 32'({1'b1, 6'h01}));

    for (int k = 0; k < 4; k++) run_char(vecs[k]);
    check("score_after_4", 32'(bus_a.score), 32'd2);

    // Reset in the middle of SHOW for character 4
    wait_display();
    check("char4_pattern", 32'(bus_a.display_pattern), 32'(rom_val(4)));
    do_tick();
    cyc(1);
    rst = 1'b0;
    cyc(1);
    check("midshow_reset", pack_a(), 32'd0);
    rst = 1'b1;
    cyc(3);
    check("reset_stays_idle", pack_a(), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    m_addr  = 0;
    m_score = 0;

    // Full lesson on the 3-character instance, lockstep with the large one
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    for (int k = 4; k < 7; k++) run_char(vecs[k]);
    check("small_done", 32'({bus_b.done, bus_b.busy, bus_b.score, bus_b.rom_addr}),
          32'({1'b1, 1'b0, 5'd3, 5'd2}));
    check("large_continues", 32'({bus_a.done, bus_a.busy, bus_a.rom_addr}), 32'({1'b0, 1'b1, 5'd3}));
    cyc(3);
    check("small_holds", 32'({bus_b.done, bus_b.score}), 32'({1'b1, 5'd3}));
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    check("small_restart", 32'({bus_b.done, bus_b.busy, bus_b.score, bus_b.rom_addr}),
          32'({1'b0, 1'b1, 5'd0, 5'd0}));

    cyc(4);
    check("queue_empty_end", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
